// File: rtl/i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen
//
// Four-phase I2C SCL generator. While cs is high, each SCL period is split
// into LOW_A, LOW_B, HIGH_A and HIGH_B quarters of (divisor+1) in_clock cycles.
// A HIGH_WAIT state sits between the low and high halves. There the generator
// releases SCL and, when STRETCH=1, waits for the synchronised bus level to go
// high. This lets a slave stretch the clock. An optional timeout aborts a
// stretch that lasts too long. A period that has started always completes
// before the generator stops. While stopped, the generator leaves SCL
// released (high).
//
// Parameters
//   DIV_W       width of the divisor port
//   STRETCH     1: wait in HIGH_WAIT for scl_sync high; 0: HIGH_WAIT is 1 cycle
//   STRETCH_TO  maximum HIGH_WAIT cycles before abort; 0 disables the timeout
//
// Ports
//   in_clock      in   reference clock, all logic on its rising edge
//   reset         in   synchronous, active-high
//   divisor       in   quarter-period length minus 1 (latched at period start)
//   cs            in   run enable
//   scl_in        in   bus SCL level, asynchronous (2-flop synchronised)
//   scl_out       out  1 = release SCL, 0 = drive low
//   tick_fall     out  pulse, first cycle of LOW_A (SCL driven low)
//   tick_low_mid  out  pulse, first cycle of LOW_B (SDA change point)
//   tick_rise     out  pulse, first cycle of HIGH_A (SCL seen high)
//   tick_high_mid out  pulse, first cycle of HIGH_B (SDA sample point)
//   busy          out  high whenever the FSM is not IDLE
//   stretched     out  high while in HIGH_WAIT with scl_sync low
//   stretch_err   out  pulse, stretch timeout abort (first IDLE cycle)
// -----------------------------------------------------------------------------
module i2c_scl_gen #(
  parameter int DIV_W      = 10,
  parameter int STRETCH    = 1,
  parameter int STRETCH_TO = 0
) (
  input  logic             in_clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             cs,
  input  logic             scl_in,
  output logic             scl_out,
  output logic             tick_fall,
  output logic             tick_low_mid,
  output logic             tick_rise,
  output logic             tick_high_mid,
  output logic             busy,
  output logic             stretched,
  output logic             stretch_err
);

  // The stretch counter keeps at least one bit so that the design stays legal
  // when the timeout is disabled.
  localparam int TO_W    = (STRETCH_TO > 0) ? $clog2(STRETCH_TO + 1) : 1;
  localparam int TO_LAST = (STRETCH_TO > 0) ? (STRETCH_TO - 1) : 0;
  localparam logic [TO_W-1:0] TO_LAST_V = TO_W'(TO_LAST);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW_A     = 3'd1,
    LOW_B     = 3'd2,
    HIGH_WAIT = 3'd3,
    HIGH_A    = 3'd4,
    HIGH_B    = 3'd5
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [TO_W-1:0]  hw_cnt;
  logic             sync_meta;
  logic             scl_sync;
  logic             quarter_done;
  logic             wait_expired;

  // A quarter ends in the cycle where the counter reaches the latched divisor.
  assign quarter_done = (cnt == div_q);

  // HIGH_WAIT has already lasted STRETCH_TO cycles, so one more cycle would
  // exceed the limit.
  assign wait_expired = (STRETCH_TO > 0) && (hw_cnt == TO_LAST_V);

  // Two-flop synchroniser for the asynchronous bus level. It resets high
  // because a released bus reads high.
  always_ff @(posedge in_clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      scl_sync  <= 1'b1;
    end else begin
      sync_meta <= scl_in;
      scl_sync  <= sync_meta;
    end
  end

  // Phase FSM. All outputs are registered, and each strobe is set on the edge
  // that enters its state. Because of this, every strobe lines up with the
  // scl_out change it marks.
  always_ff @(posedge in_clock) begin
    if (reset) begin
      state         <= IDLE;
      scl_out       <= 1'b1;
      tick_fall     <= 1'b0;
      tick_low_mid  <= 1'b0;
      tick_rise     <= 1'b0;
      tick_high_mid <= 1'b0;
      busy          <= 1'b0;
      stretched     <= 1'b0;
      stretch_err   <= 1'b0;
      cnt           <= '0;
      div_q         <= '0;
      hw_cnt        <= '0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      tick_fall     <= 1'b0;
      tick_low_mid  <= 1'b0;
      tick_rise     <= 1'b0;
      tick_high_mid <= 1'b0;
      stretched     <= 1'b0;
      stretch_err   <= 1'b0;

      case (state)
        IDLE: begin
          cnt    <= '0;
          hw_cnt <= '0;
          if (cs) begin
            state     <= LOW_A;
            scl_out   <= 1'b0;
            tick_fall <= 1'b1;
            busy      <= 1'b1;
            div_q     <= divisor;
          end else begin
            state   <= IDLE;
            scl_out <= 1'b1;
            busy    <= 1'b0;
          end
        end

        LOW_A: begin
          if (quarter_done) begin
            state        <= LOW_B;
            tick_low_mid <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + DIV_W'(1'b1);
          end
        end

        LOW_B: begin
          if (quarter_done) begin
            state   <= HIGH_WAIT;
            scl_out <= 1'b1;
            cnt     <= '0;
            hw_cnt  <= '0;
            // sync_meta is the value scl_sync takes on this same edge.
            stretched <= ~sync_meta;
          end else begin
            cnt <= cnt + DIV_W'(1'b1);
          end
        end

        HIGH_WAIT: begin
          if ((STRETCH == 0) || scl_sync) begin
            state     <= HIGH_A;
            tick_rise <= 1'b1;
            hw_cnt    <= '0;
          end else if (wait_expired) begin
            // Abort the period. SCL is already released, and cs is checked
            // again in IDLE, so a restart still begins with a clean LOW_A.
            state       <= IDLE;
            busy        <= 1'b0;
            stretch_err <= 1'b1;
            hw_cnt      <= '0;
          end else begin
            hw_cnt    <= hw_cnt + TO_W'(1'b1);
            stretched <= ~sync_meta;
          end
        end

        HIGH_A: begin
          if (quarter_done) begin
            state         <= HIGH_B;
            tick_high_mid <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + DIV_W'(1'b1);
          end
        end

        HIGH_B: begin
          if (quarter_done) begin
            cnt <= '0;
            // cs is checked only here and in IDLE. Dropping it earlier
            // still lets the current period finish.
            if (cs) begin
              state     <= LOW_A;
              scl_out   <= 1'b0;
              tick_fall <= 1'b1;
              div_q     <= divisor;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + DIV_W'(1'b1);
          end
        end

        default: begin
          state   <= IDLE;
          scl_out <= 1'b1;
          busy    <= 1'b0;
          cnt     <= '0;
          hw_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
